otp_ctrl_edn_packer: RTL and testbench
======================================

Name: otp_ctrl_edn_packer

Overview:
- Shared entropy front-end for OTP controller consumers, e.g. the LFSR timer reseed path and key-derivation scramble logic.
- Arbitrates round-robin among NumReq requesters and issues one EDN request per grant.
- Packs OutWidth/EdnBusWidth consecutive EDN bus beats into one OutWidth word, then returns it with a one-cycle ack to the granted requester.

Parameters:
- NumReq, 2, number of requesters (>=1).
- EdnBusWidth, 32, EDN bus data width.
- OutWidth, 64, delivered word width; must be an integer multiple of EdnBusWidth (checked by init assertion). NumBeats = OutWidth/EdnBusWidth.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  NumReq  per-requester entropy request, level, held until ack.
- ack_o  output  NumReq  one-hot single-cycle ack; data_o valid in the same cycle.
- data_o  output  OutWidth  packed entropy word.
- fips_o  output  1  AND of edn_fips_i over all beats of the delivered word; valid with ack.
- edn_req_o  output  1  request to EDN.
- edn_ack_i  input  1  EDN beat handshake.
- edn_bus_i  input  EdnBusWidth  EDN beat data.
- edn_fips_i  input  1  EDN FIPS flag per beat.
- fsm_err_o  output  1  invalid FSM encoding detected; sticky.

Behaviour:
- Reset values: ack_o=0, data_o=0, fips_o=0, edn_req_o=0, fsm_err_o=0. State=IdleSt, RR pointer=0, beat count=0.
- FSM uses sparse encoding with minimum Hamming distance 3. States: IdleSt, FetchSt, AckSt, ErrorSt.
- IdleSt:
  - If any req_i bit is set, grant the first set bit at or after the RR pointer, wrapping modulo NumReq.
  - Register the grant index, clear the beat count, set the fips accumulator to 1, go to FetchSt.
- FetchSt:
  - edn_req_o=1 (combinational on state).
  - On each cycle with edn_ack_i=1: data_q <= {edn_bus_i, data_q[OutWidth-1:EdnBusWidth]}, so beat 0 ends in the LSBs. fips_acc &= edn_fips_i; beat count increments.
  - On the ack of beat NumBeats-1, go to AckSt.
- AckSt:
  - ack_o[grant]=1 for exactly one cycle.
  - data_o=data_q, fips_o=fips_acc.
  - RR pointer <= (grant+1) mod NumReq. Return to IdleSt.
- Latency: req_i sampled in IdleSt at cycle t; EDN acks on every cycle give ack_o at t+1+NumBeats (t+3 for the defaults).
- Requester drops req_i mid-fetch: the fetch completes and ack is still pulsed to that index. No abort.
- req_i newly raised during FetchSt/AckSt: not granted until the next IdleSt cycle.
- Same requester holding req_i high across its own ack: it is granted again only after other pending requesters per RR order.
- edn_ack_i outside FetchSt: ignored, no shift, no count change.
- edn_req_o deasserts in the cycle after the final beat ack; never asserted outside FetchSt.
- Beat counter width is $clog2(NumBeats+1); it never wraps within a fetch.
- data_o, fips_o:
  - Outside AckSt, data_o holds data_q and fips_o holds fips_acc unless wiped (see optional feature).
  - Consumers must sample only on ack_o.
- Invalid state encoding:
  - Go to ErrorSt, fsm_err_o=1 (sticky).
  - In ErrorSt: ack_o=0, edn_req_o=0; exit only via reset.
- Reset mid-fetch: all state returns to reset values immediately. A partial word is never delivered.
- Assertions: ack_o onehot0; edn_req_o and ack_o known.

Optional Feature:
- Macro: OTP_CTRL_EDN_PACKER_WIPE_EN.
- Defined:
  - data_q and fips_acc clear to 0 in the cycle after AckSt, so data_o=0 everywhere outside AckSt.
  - The shift register is also cleared on entry to FetchSt.
- Undefined: data_q retains the last delivered word until overwritten by the next fetch.

Test Plan:
- Single request: req_i=2'b01; EDN acks in consecutive cycles with 32'hAAAA_0001, 32'hBBBB_0002, fips=1 -> ack_o=2'b01 exactly 3 cycles after the req is sampled; data_o=64'hBBBB_0002_AAAA_0001; fips_o=1.
- Round-robin: req_i=2'b11 held -> grants in order 0,1,0,1 on successive ack_o pulses; edn_req_o low for exactly 1 cycle between fetches (AckSt) plus 1 (IdleSt).
- FIPS and stall: beat 0 fips=1, beat 1 fips=0, 3 idle cycles between EDN acks -> fips_o=0; ack_o delayed by 3 cycles; edn_req_o held high across the gap.
- Drop request: req_i[1] deasserted after beat 0 -> ack_o=2'b10 still pulses once; RR pointer moves to 0.
- Reset mid-fetch: rst_ni low after 1 beat, then release; req_i=2'b01 -> first ack carries 2 fresh beats only. With WIPE_EN: data_o=0 after reset and in the cycle after ack.
- Fault: force the state register to an unused encoding -> fsm_err_o=1 the next cycle and stays 1; further req_i produces no ack_o and no edn_req_o until reset.

Source files
------------

// File: rtl/otp_ctrl_edn_packer.sv
// otp_ctrl_edn_packer: shared EDN entropy front-end for OTP controller consumers.
// Arbitrates round-robin among NumReq requesters, fetches NumBeats EDN beats per
// grant, packs them LSB-first into one OutWidth word and returns it with a
// single-cycle ack to the granted requester.
// Optional feature macro: OTP_CTRL_EDN_PACKER_WIPE_EN (clears the packed word
// and FIPS accumulator outside the ack cycle).
module otp_ctrl_edn_packer #(
   parameter int NumReq      = 2,
   parameter int EdnBusWidth = 32,
   parameter int OutWidth    = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumReq-1:0]      req_i,
   output logic [NumReq-1:0]      ack_o,
   output logic [OutWidth-1:0]    data_o,
   output logic                   fips_o,
   output logic                   edn_req_o,
   input  logic                   edn_ack_i,
   input  logic [EdnBusWidth-1:0] edn_bus_i,
   input  logic                   edn_fips_i,
   output logic                   fsm_err_o
);

   localparam int NumBeats = OutWidth / EdnBusWidth;
   localparam int CntW     = $clog2(NumBeats + 1);
   localparam int IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1;

   // Elaboration-time guard: the word must be a whole number of EDN beats.
   if ((OutWidth % EdnBusWidth) != 0 || OutWidth < EdnBusWidth) begin : g_bad_width
      $error("OutWidth must be a non-zero integer multiple of EdnBusWidth");
   end

   // Sparse state encoding, pairwise Hamming distance >= 3, so a single
   // upset can never turn one legal state into another.
   typedef enum logic [4:0] {
      IdleSt  = 5'b00111,
      FetchSt = 5'b11100,
      AckSt   = 5'b10010,
      ErrorSt = 5'b01001
   } state_e;

   logic [4:0]          r_state;
   logic [IdxW-1:0]     r_ptr;
   logic [IdxW-1:0]     r_gnt;
   logic [CntW-1:0]     r_cnt;
   logic [OutWidth-1:0] r_data;
   logic                r_fips;
   logic [NumReq-1:0]   r_ack;
   logic                r_err;

   logic                w_any;
   logic [IdxW-1:0]     w_gnt_idx;
   logic [IdxW-1:0]     w_k;
   logic [IdxW-1:0]     w_ptr_next;
   logic [NumReq-1:0]   w_gnt_oh;
   logic [OutWidth-1:0] w_shift;

   // Round-robin search: first set request at or after the pointer, wrapping.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      w_any     = 1'b0;
      w_gnt_idx = '0;
      w_k       = '0;
      for (int i = 0; i < NumReq; i++) begin
         w_k = IdxW'((int'(r_ptr) + i) % NumReq);
         if (!w_any && req_i[w_k]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_k;
         end
      end
   end

   assign w_ptr_next = (r_gnt == IdxW'(NumReq - 1)) ? '0 : r_gnt + 1'b1;
   assign w_gnt_oh   = NumReq'(1) << r_gnt;

   // New beat enters at the top, so beat 0 ends up in the LSBs.
   if (NumBeats > 1) begin : g_shift
      assign w_shift = {edn_bus_i, r_data[OutWidth-1:EdnBusWidth]};
   end else begin : g_single
      assign w_shift = edn_bus_i;
   end

   // Control FSM, arbitration state, beat packing and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IdleSt;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_fips  <= 1'b0;
         r_ack   <= '0;
         r_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         r_ack <= '0;
         case (r_state)
            IdleSt: begin
               if (w_any) begin
                  r_gnt   <= w_gnt_idx;
                  r_cnt   <= '0;
                  r_fips  <= 1'b1;
                  r_state <= FetchSt;
`ifdef OTP_CTRL_EDN_PACKER_WIPE_EN
                  r_data  <= '0;
`endif
               end
            end
            FetchSt: begin
               if (edn_ack_i) begin
                  r_data <= w_shift;
                  r_fips <= r_fips & edn_fips_i;
                  r_cnt  <= r_cnt + 1'b1;
                  if (r_cnt == CntW'(NumBeats - 1)) begin
                     r_state <= AckSt;
                     r_ack   <= w_gnt_oh;
                  end
               end
            end
            AckSt: begin
               r_ptr   <= w_ptr_next;
               r_state <= IdleSt;
`ifdef OTP_CTRL_EDN_PACKER_WIPE_EN
               r_data  <= '0;
               r_fips  <= 1'b0;
`endif
            end
            ErrorSt: begin
               r_err <= 1'b1;
            end
            default: begin
               r_state <= ErrorSt;
               r_err   <= 1'b1;
            end
         endcase
      end
   end

   assign ack_o     = r_ack;
   assign data_o    = r_data;
   assign fips_o    = r_fips;
   assign edn_req_o = (r_state == FetchSt);
   assign fsm_err_o = r_err;

   // Output protocol invariants.
   a_ack_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ack_o));
   a_ack_known   : assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(ack_o));
   a_req_known   : assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(edn_req_o));

endmodule

// File: tb/tb_otp_ctrl_edn_packer.sv
// Self-checking bench for otp_ctrl_edn_packer: directed steps drive requests and
// EDN beats, expected words are queued at stimulus time and compared on ack_o.
module tb_otp_ctrl_edn_packer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [1:0]  req_i;
   logic [1:0]  ack_o;
   logic [63:0] data_o;
   logic        fips_o;
   logic        edn_req_o;
   logic        edn_ack_i;
   logic [31:0] edn_bus_i;
   logic        edn_fips_i;
   logic        fsm_err_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  ack;
      logic [63:0] data;
      logic        fips;
   } exp_t;

   exp_t sb[$];
   logic [63:0] last_word;

   otp_ctrl_edn_packer #(.NumReq(2), .EdnBusWidth(32), .OutWidth(64)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .ack_o      (ack_o),
      .data_o     (data_o),
      .fips_o     (fips_o),
      .edn_req_o  (edn_req_o),
      .edn_ack_i  (edn_ack_i),
      .edn_bus_i  (edn_bus_i),
      .edn_fips_i (edn_fips_i),
      .fsm_err_o  (fsm_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One EDN beat accepted at the next rising edge.
   task automatic beat(input logic [31:0] d, input logic f);
      edn_ack_i  = 1'b1;
      edn_bus_i  = d;
      edn_fips_i = f;
      tick();
      edn_ack_i  = 1'b0;
      edn_bus_i  = '0;
      edn_fips_i = 1'b0;
   endtask

   task automatic push(input logic [1:0] a, input logic [31:0] b0, input logic [31:0] b1,
                       input logic f);
      exp_t e;
      e.ack  = a;
      e.data = {b1, b0};
      e.fips = f;
      sb.push_back(e);
   endtask

   // Scoreboard: every ack pulse is matched against the oldest expected word.
   always @(negedge clk_i) begin
      if (rst_ni === 1'b1 && ack_o !== 2'b00) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_ack", {62'd0, ack_o}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_ack", {62'd0, ack_o}, {62'd0, e.ack});
            check("sb_data", data_o, e.data);
            check("sb_fips", {63'd0, fips_o}, {63'd0, e.fips});
         end
      end
   end

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      check("rst_ack", {62'd0, ack_o}, 64'd0);
      check("rst_data", data_o, 64'd0);
      check("rst_edn_req", {63'd0, edn_req_o}, 64'd0);
      check("rst_fsm_err", {63'd0, fsm_err_o}, 64'd0);
      tick();
      rst_ni = 1'b1;
   endtask

   initial begin
      rst_ni     = 1'b0;
      req_i      = '0;
      edn_ack_i  = 1'b0;
      edn_bus_i  = '0;
      edn_fips_i = 1'b0;
      tick();
      tick();
      check("reset_fips", {63'd0, fips_o}, 64'd0);
      do_reset();

      // Single request: ack three cycles after the request is sampled.
      req_i = 2'b01;
      tick();
      check("t1_edn_req_fetch", {63'd0, edn_req_o}, 64'd1);
      push(2'b01, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1);
      beat(32'hAAAA_0001, 1'b1);
      check("t1_no_early_ack", {62'd0, ack_o}, 64'd0);
      beat(32'hBBBB_0002, 1'b1);
      check("t1_ack", {62'd0, ack_o}, 64'd1);
      check("t1_data", data_o, 64'hBBBB_0002_AAAA_0001);
      check("t1_fips", {63'd0, fips_o}, 64'd1);
      check("t1_edn_req_ack", {63'd0, edn_req_o}, 64'd0);
      req_i = 2'b00;
      tick();
      check("t1_ack_single", {62'd0, ack_o}, 64'd0);
`ifdef OTP_CTRL_EDN_PACKER_WIPE_EN
      check("t1_wipe_after_ack", data_o, 64'd0);
`else
      check("t1_hold_after_ack", data_o, 64'hBBBB_0002_AAAA_0001);
`endif

      // Round-robin with both requesters held: grants 0,1,0,1.
      do_reset();
      req_i = 2'b11;
      tick();
      for (int i = 0; i < 4; i++) begin
         logic [1:0] oh;
         oh = (i % 2 == 0) ? 2'b01 : 2'b10;
         push(oh, 32'hC000_0000 | i, 32'hD000_0000 | i, 1'b1);
         beat(32'hC000_0000 | i, 1'b1);
         beat(32'hD000_0000 | i, 1'b1);
         check("rr_grant", {62'd0, ack_o}, {62'd0, oh});
         check("rr_edn_req_ack", {63'd0, edn_req_o}, 64'd0);
         if (i == 3) begin
            req_i = 2'b00;
         end else begin
            tick();
            check("rr_edn_req_idle", {63'd0, edn_req_o}, 64'd0);
            tick();
            check("rr_edn_req_refetch", {63'd0, edn_req_o}, 64'd1);
         end
      end
      tick();

      // FIPS low on beat 1 and a 3-cycle stall between beats.
      req_i = 2'b01;
      tick();
      push(2'b01, 32'h1111_1111, 32'h2222_2222, 1'b0);
      beat(32'h1111_1111, 1'b1);
      for (int g = 0; g < 3; g++) begin
         check("t3_edn_req_gap", {63'd0, edn_req_o}, 64'd1);
         check("t3_no_ack_gap", {62'd0, ack_o}, 64'd0);
         tick();
      end
      beat(32'h2222_2222, 1'b0);
      check("t3_ack", {62'd0, ack_o}, 64'd1);
      check("t3_fips", {63'd0, fips_o}, 64'd0);
      req_i = 2'b00;
      tick();
      last_word = 64'h2222_2222_1111_1111;

      // EDN acks while idle must not touch the packed word.
      edn_ack_i = 1'b1;
      edn_bus_i = 32'hDEAD_BEEF;
      tick();
      tick();
      edn_ack_i = 1'b0;
      edn_bus_i = '0;
      check("idle_edn_req", {63'd0, edn_req_o}, 64'd0);
`ifdef OTP_CTRL_EDN_PACKER_WIPE_EN
      check("idle_ack_ignored", data_o, 64'd0);
`else
      check("idle_ack_ignored", data_o, last_word);
`endif

      // Requester 1 drops its request after beat 0; ack still delivered.
      req_i = 2'b10;
      tick();
      push(2'b10, 32'h3333_0003, 32'h4444_0004, 1'b1);
      beat(32'h3333_0003, 1'b1);
      req_i = 2'b00;
      beat(32'h4444_0004, 1'b1);
      check("t4_drop_ack", {62'd0, ack_o}, 64'd2);
      tick();
      check("t4_single", {62'd0, ack_o}, 64'd0);
      // Pointer must now be 0: both requesting picks requester 0.
      req_i = 2'b11;
      tick();
      push(2'b01, 32'h5555_0005, 32'h6666_0006, 1'b1);
      beat(32'h5555_0005, 1'b1);
      beat(32'h6666_0006, 1'b1);
      check("t4_ptr_wrap", {62'd0, ack_o}, 64'd1);
      req_i = 2'b00;
      tick();

      // Reset mid-fetch: partial word discarded, next word has fresh beats only.
      req_i = 2'b01;
      tick();
      beat(32'hBAD0_BAD0, 1'b0);
      do_reset();
      push(2'b01, 32'h7777_0007, 32'h8888_0008, 1'b1);
      tick();
      check("t5_refetch", {63'd0, edn_req_o}, 64'd1);
      beat(32'h7777_0007, 1'b1);
      beat(32'h8888_0008, 1'b1);
      check("t5_ack", {62'd0, ack_o}, 64'd1);
      check("t5_data", data_o, 64'h8888_0008_7777_0007);
      req_i = 2'b00;
      tick();

      // Fault: illegal state encoding traps into a sticky error state.
      force dut.r_state = 5'b10101;
      #1;
      release dut.r_state;
      tick();
      check("t6_fsm_err", {63'd0, fsm_err_o}, 64'd1);
      check("t6_edn_req", {63'd0, edn_req_o}, 64'd0);
      req_i = 2'b01;
      for (int c = 0; c < 4; c++) begin
         edn_ack_i = 1'b1;
         tick();
         check("t6_no_ack", {62'd0, ack_o}, 64'd0);
         check("t6_no_edn_req", {63'd0, edn_req_o}, 64'd0);
         check("t6_err_sticky", {63'd0, fsm_err_o}, 64'd1);
      end
      edn_ack_i = 1'b0;
      req_i     = 2'b00;
      do_reset();
      tick();
      check("t6_err_cleared", {63'd0, fsm_err_o}, 64'd0);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
